// File: rtl/seq_generator.sv
// -----------------------------------------------------------------------------
// seq_generator
//   Serial pattern transmitter. A WIDTH-bit pattern and a repeat count are
//   taken over a valid/ready handshake while idle, then the pattern is driven
//   MSB-first on 'out', one bit per clk, max(reps,1) times.
//
// Configuration macro:
//   SEQ_GENERATOR_GAP_EN  when defined, one idle (out_valid=0) cycle is
//                         inserted between consecutive repetitions. When
//                         undefined, repetitions are back-to-back.
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous reset, active-low
//   load_valid  pattern/reps offered
//   load_ready  block accepts a load (IDLE only)
//   pattern     bits to send, bit WIDTH-1 first
//   reps        repetition count, 0 treated as 1
//   abort       synchronous abort of a transfer in progress
//   out         serial data bit (0 whenever out_valid=0)
//   out_valid   'out' carries a pattern bit this cycle
//   busy        state != IDLE
//   done        one-cycle pulse after the last bit of the last repetition
//   cstate      registered FSM state (debug)
//   nstate      combinational next state (debug)
//
// State | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a load, load_ready=1
// SHIFT | a pattern bit is on 'out' this cycle
// GAP   | one idle cycle between repetitions (gap build only)
// DONE  | single-cycle completion pulse, then back to IDLE
// -----------------------------------------------------------------------------
module seq_generator #(
  parameter int WIDTH = 8,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] pattern,
  input  logic [REP_W-1:0] reps,
  input  logic             abort,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       cstate,
  output logic [1:0]       nstate
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    GAP   = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t           state_q, state_d;
  // shreg_q holds the bits still to be sent after the one currently on 'out',
  // MSB-aligned; bit_cnt_q is the index of the bit currently on 'out'.
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] copy_q;
  logic [REP_W-1:0] rep_left_q;
  logic [CW-1:0]    bit_cnt_q;
  logic             out_q, out_valid_q;

  logic             rep_end;
  logic             more_reps;
  logic             next_bit;
  logic             out_d;

  always_comb begin
    rep_end   = (bit_cnt_q == '0);
    more_reps = (rep_left_q > REP_W'(1));
    state_d   = state_q;
    next_bit  = 1'b0;

    case (state_q)
      IDLE: begin
        // abort is deliberately not looked at here: a load always wins
        if (load_valid) begin
          state_d  = SHIFT;
          next_bit = pattern[WIDTH-1];
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (!rep_end) begin
          next_bit = shreg_q[WIDTH-1];
        end else if (more_reps) begin
`ifdef SEQ_GENERATOR_GAP_EN
          state_d  = GAP;
`else
          state_d  = SHIFT;
          next_bit = copy_q[WIDTH-1];
`endif
        end else begin
          state_d = DONE;
        end
      end
      GAP: begin
`ifdef SEQ_GENERATOR_GAP_EN
        if (abort) begin
          state_d = IDLE;
        end else begin
          state_d  = SHIFT;
          next_bit = copy_q[WIDTH-1];
        end
`else
        state_d = IDLE;
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    out_d = (state_d == SHIFT) ? next_bit : 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      copy_q      <= '0;
      rep_left_q  <= '0;
      bit_cnt_q   <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      out_valid_q <= (state_d == SHIFT);

      case (state_q)
        IDLE: begin
          if (load_valid) begin
            shreg_q    <= {pattern[WIDTH-2:0], 1'b0};
            copy_q     <= pattern;
            rep_left_q <= (reps == '0) ? REP_W'(1) : reps;
            bit_cnt_q  <= LAST_BIT;
          end
        end
        SHIFT: begin
          if (!abort) begin
            if (!rep_end) begin
              shreg_q   <= {shreg_q[WIDTH-2:0], 1'b0};
              bit_cnt_q <= bit_cnt_q - CW'(1);
            end else if (more_reps) begin
              // Rearm for the next repetition now; in the gap build the GAP
              // cycle then only has to present copy_q's MSB.
              shreg_q    <= {copy_q[WIDTH-2:0], 1'b0};
              bit_cnt_q  <= LAST_BIT;
              rep_left_q <= rep_left_q - REP_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign out        = out_q;
  assign out_valid  = out_valid_q;
  assign cstate     = state_q;
  assign nstate     = state_d;
  assign busy       = (state_q != IDLE);
  assign load_ready = (state_q == IDLE);
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_seq_generator.sv
module tb_seq_generator;

  localparam int WIDTH = 8;
  localparam int REP_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             load_valid = 1'b0;
  logic             abort = 1'b0;
  logic [WIDTH-1:0] pattern = '0;
  logic [REP_W-1:0] reps = '0;
  logic             load_ready, out, out_valid, busy, done;
  logic [1:0]       cstate, nstate;

  int n_chk  = 0;
  int n_fail = 0;

  seq_generator #(.WIDTH(WIDTH), .REP_W(REP_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .pattern    (pattern),
    .reps       (reps),
    .abort      (abort),
    .out        (out),
    .out_valid  (out_valid),
    .busy       (busy),
    .done       (done),
    .cstate     (cstate),
    .nstate     (nstate)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Loads pat/r, records {out_valid,out} every cycle until done, and compares
  // against a stream built from the pattern. busy_at >= 0 offers an 8'hFF
  // load in that cycle of the transfer, which must be ignored.
  task automatic send_and_check(input string tag, input logic [7:0] pat,
                                input logic [3:0] r, input int busy_at);
    logic [1:0] exp_q[$];
    logic [1:0] got_q[$];
    int         nr;
    bit         seen_done;
    nr = (r == 0) ? 1 : int'(r);
    for (int k = 0; k < nr; k++) begin
`ifdef SEQ_GENERATOR_GAP_EN
      if (k > 0) exp_q.push_back(2'b00);
`endif
      for (int b = 7; b >= 0; b--) exp_q.push_back({1'b1, pat[b]});
    end
    pattern    = pat;
    reps       = r;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    pattern    = '0;
    reps       = '0;
    seen_done  = 1'b0;
    for (int i = 0; i < 300 && !seen_done; i++) begin
      if (done) begin
        seen_done = 1'b1;
      end else begin
        got_q.push_back({out_valid, out});
        if (i == busy_at) begin
          load_valid = 1'b1;
          pattern    = 8'hFF;
          reps       = 4'hF;
        end else begin
          load_valid = 1'b0;
        end
        tick();
      end
    end
    load_valid = 1'b0;
    pattern    = '0;
    reps       = '0;
    check({tag, " done_seen"}, 32'(seen_done), 32'd1);
    check({tag, " length"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s bit%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    check({tag, " done_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, " done_out"}, 32'(out), 32'd0);
    check({tag, " done_load_ready"}, 32'(load_ready), 32'd0);
    check({tag, " done_cstate"}, 32'(cstate), 32'd3);
    tick();
    check({tag, " idle_cstate"}, 32'(cstate), 32'd0);
    check({tag, " idle_done"}, 32'(done), 32'd0);
    check({tag, " idle_load_ready"}, 32'(load_ready), 32'd1);
    check({tag, " idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before test end");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset cstate", 32'(cstate), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset load_ready", 32'(load_ready), 32'd1);
    check("reset done", 32'(done), 32'd0);
    rst = 1'b1;
    tick();

    // Async reset mid-SHIFT
    pattern = 8'hFF; reps = 4'd1; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    check("pre_rst out", 32'(out), 32'd1);
    tick(); tick();
    #2 rst = 1'b0;
    #1;
    check("mid_rst out", 32'(out), 32'd0);
    check("mid_rst out_valid", 32'(out_valid), 32'd0);
    check("mid_rst cstate", 32'(cstate), 32'd0);
    check("mid_rst load_ready", 32'(load_ready), 32'd1);
    check("mid_rst busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    send_and_check("single", 8'b1101_0110, 4'd0, -1);
    send_and_check("rep1", 8'b1101_0110, 4'd1, -1);
    send_and_check("repeat3", 8'b1100_0000, 4'd3, -1);
    send_and_check("busy_load", 8'b1101_0110, 4'd2, 3);
    send_and_check("busy_load_late", 8'h01, 4'd2, 10);
    send_and_check("rep15", 8'h5A, 4'd15, -1);

    // Abort at the 4th bit of 8'hA5 = 1010_0101
    pattern = 8'hA5; reps = 4'd2; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("abort bit%0d", i), 32'({out_valid, out}),
            32'({1'b1, (i % 2 == 0) ? 1'b1 : 1'b0}));
      if (i == 3) abort = 1'b1;
      tick();
    end
    abort = 1'b0;
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort out", 32'(out), 32'd0);
    check("abort cstate", 32'(cstate), 32'd0);
    check("abort done", 32'(done), 32'd0);
    tick();
    check("abort done_later", 32'(done), 32'd0);
    check("abort load_ready", 32'(load_ready), 32'd1);
    send_and_check("after_abort", 8'h3C, 4'd1, -1);

    // abort together with load in IDLE: load wins
    pattern = 8'h81; reps = 4'd1; load_valid = 1'b1; abort = 1'b1;
    tick();
    load_valid = 1'b0; abort = 1'b0;
    check("abort_load cstate", 32'(cstate), 32'd1);
    check("abort_load first", 32'({out_valid, out}), 32'd3);
    for (int i = 0; i < 50 && !done; i++) tick();
    check("abort_load done", 32'(done), 32'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
